// File: rtl/dm_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : dm_button_conditioner
// Brief   : Synchronise and debounce four direction buttons and emit one-hot,
//           single-cycle move pulses with optional auto-repeat.
// Rev     : 1.0  initial release
// ============================================================================
module dm_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic power,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_right,
    input  logic btn_left,
    output logic up,
    output logic down,
    output logic right,
    output logic left,
    output logic held
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_LOCK   = 2'd3;

    localparam logic [CNT_W-1:0] c_debounce   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_delay_load = (REPEAT_DELAY == 0) ? '0 : CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rate_load  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             c_repeat_en  = (REPEAT_DELAY != 0);

    logic [3:0]       w_raw;
    logic [3:0]       w_deb;
    logic             w_dir_valid;
    logic             w_any;

    logic [1:0]       r_state;
    logic [3:0]       r_dir_q;
    logic [3:0]       r_pulse;
    logic             r_held;
    logic             r_power_q;
    logic [CNT_W-1:0] r_timer;

    assign w_raw = {btn_left, btn_down, btn_right, btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic [CNT_W-1:0] r_cnt;

            // Flip only after the mismatch has outlived the full count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_debounce) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    assign w_dir_valid = $onehot(w_deb);
    assign w_any       = |w_deb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dir_q   <= '0;
            r_pulse   <= '0;
            r_held    <= 1'b0;
            r_power_q <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_power_q <= power;
            r_pulse   <= '0;
            r_held    <= power & w_dir_valid;
            if (r_timer != '0) begin
                r_timer <= r_timer - CNT_W'(1);
            end
            if (!power) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A button already down at power-up must be released first.
                        if (!r_power_q && w_any) begin
                            r_state <= S_LOCK;
                        end else if (w_dir_valid) begin
                            r_pulse <= w_deb;
                            r_dir_q <= w_deb;
                            r_timer <= c_delay_load;
                            r_state <= S_PRESS;
                        end else if (w_any) begin
                            r_state <= S_LOCK;
                        end
                    end
                    S_PRESS, S_REPEAT: begin
                        if (!w_any) begin
                            r_state <= S_IDLE;
                        end else if (w_deb != r_dir_q) begin
                            r_state <= S_LOCK;
                        end else if (c_repeat_en && (r_timer == '0)) begin
                            r_pulse <= r_dir_q;
                            r_timer <= c_rate_load;
                            r_state <= S_REPEAT;
                        end
                    end
                    S_LOCK: begin
                        if (!w_any) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign up    = r_pulse[0];
    assign right = r_pulse[1];
    assign down  = r_pulse[2];
    assign left  = r_pulse[3];
    assign held  = r_held;

endmodule
`default_nettype wire
